// File: rtl/chan_mux_pkg.sv
// Shared constants for the chan_mux_rr channel multiplexer and its arbiter.
package chan_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int MAX_CH = 16;
    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/chan_mux_rr_if.sv
// Producer/consumer bundle for chan_mux_rr: N input streams, one output stream.
interface chan_mux_rr_if #(
    parameter int N_CH  = 3,
    parameter int WIDTH = 8,
    parameter int CH_W  = $clog2(N_CH)
);

    logic                    mode;
    logic [CH_W-1:0]         sel;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [CH_W-1:0]         out_ch;
    logic                    out_ready;
    logic                    sel_err;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch, sel_err
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch, sel_err
    );

endinterface

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr+1 sits at bit 0,
// find the first set bit, then map the offset back to a channel index.
module rr_arbiter #(
    parameter int N_CH = 3,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic            gnt_valid_o,
    output logic [CH_W-1:0] gnt_idx_o
);

    localparam logic [CH_W:0] N_EXT = (CH_W+1)'(N_CH);

    logic [CH_W:0]     start;
    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [CH_W:0]     off;
    logic [CH_W:0]     sum;

    // Doubling the vector turns the modulo-N rotate into a plain right shift.
    assign start   = {1'b0, ptr_i} + (CH_W+1)'(1);
    assign req_dbl = {req_i, req_i};
    assign req_rot = N_CH'(req_dbl >> start);

    always_comb begin
        gnt_valid_o = 1'b0;
        off         = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_valid_o = 1'b1;
                off         = (CH_W+1)'(i);
            end
        end
        sum = start + off;
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        gnt_idx_o = sum[CH_W-1:0];
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux with valid/ready on every port; direct-select or
// round-robin grant, one cycle of latency at full throughput.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    chan_mux_rr_if.slave bus
);

    localparam int              CH_W    = $clog2(N_CH);
    localparam logic [CH_W:0]   N_EXT   = (CH_W+1)'(N_CH);
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(N_CH - 1);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]  out_ch_q,    out_ch_d;
    logic [CH_W-1:0]  ptr_q,       ptr_d;
    logic             sel_err_q,   sel_err_d;

    logic             free;
    logic             sel_legal;
    logic             rr_valid;
    logic [CH_W-1:0]  rr_idx;
    logic             gnt_valid;
    logic [CH_W-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req_i       (bus.in_valid),
        .ptr_i       (ptr_q),
        .gnt_valid_o (rr_valid),
        .gnt_idx_o   (rr_idx)
    );

    assign free      = !out_valid_q || bus.out_ready;
    assign sel_legal = {1'b0, bus.sel} < N_EXT;

    // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_data  = '0;
        if (bus.mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else if (sel_legal) begin
            gnt_idx = bus.sel;
            for (int k = 0; k < N_CH; k++) begin
                if (bus.sel == CH_W'(k)) gnt_valid = bus.in_valid[k];
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_idx == CH_W'(k)) gnt_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // Ready is held low during reset even though the empty register looks free.
    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.in_ready[k] = rst_n && free && gnt_valid && (gnt_idx == CH_W'(k));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        sel_err_d   = (bus.mode == MODE_SEL) && !sel_legal;
        if (free) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt_idx;
                if (bus.mode == MODE_RR) ptr_d = gnt_idx;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= PTR_RST;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Self-checking bench for chan_mux_rr: behavioural cycle model plus a word
// scoreboard, directed scenarios followed by randomised traffic.
module tb_chan_mux_rr;
    import chan_mux_pkg::*;

    parameter int N_CH  = 3;
    parameter int WIDTH = 8;
    localparam int CH_W = $clog2(N_CH);
    localparam logic SEL_MAX_ILLEGAL = (((1 << CH_W) - 1) >= N_CH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    chan_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    chan_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic            m_valid;
    logic [CH_W-1:0] m_ptr;
    logic            m_err;
    word_t           sb_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_valid = 1'b0;
        m_ptr   = CH_W'(N_CH - 1);
        m_err   = 1'b0;
        sb_q.delete();
    endfunction

    // Reference grant: linear search from the pointer, independent of the RTL's rotate/ffs.
    function automatic void model_grant(output logic gv, output int g);
        logic [N_CH-1:0] v;
        int c;
        gv = 1'b0;
        g  = 0;
        if (bus.mode == MODE_SEL) begin
            if (int'(bus.sel) < N_CH) begin
                v = bus.in_valid >> bus.sel;
                if (v[0]) begin
                    gv = 1'b1;
                    g  = int'(bus.sel);
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                c = (int'(m_ptr) + k) % N_CH;
                v = bus.in_valid >> c;
                if (!gv && v[0]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    task automatic set_data();
        for (int k = 0; k < N_CH; k++) bus.in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    // One clock: check handshake and outputs mid-cycle, then advance the model.
    task automatic tick();
        logic gv;
        int g;
        logic free;
        logic [N_CH-1:0] exp_rdy;
        word_t w;
        @(negedge clk);
        model_grant(gv, g);
        free    = !m_valid || bus.out_ready;
        exp_rdy = (free && gv) ? (N_CH'(1) << g) : '0;
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, m_valid);
        check("sel_err", bus.sel_err, m_err);
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", bus.out_valid, 0);
            end else begin
                w = sb_q.pop_front();
                check("sb_data", bus.out_data, w.data);
                check("sb_ch", bus.out_ch, w.ch);
            end
        end
        @(posedge clk);
        m_err = (bus.mode == MODE_SEL) && (int'(bus.sel) >= N_CH);
        if (free) begin
            m_valid = gv;
            if (gv) begin
                w.data = bus.in_data[g*WIDTH +: WIDTH];
                w.ch   = CH_W'(g);
                sb_q.push_back(w);
                if (bus.mode == MODE_RR) m_ptr = CH_W'(g);
            end
        end
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_ch"}, bus.out_ch, 0);
        check({tag, "_sel_err"}, bus.sel_err, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mode      = MODE_RR;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        set_data();
        model_reset();

        // Reset state, with every input valid to show in_ready stays low.
        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Direct select of the highest channel.
        bus.mode     = MODE_SEL;
        bus.sel      = CH_W'(N_CH - 1);
        bus.in_valid = '1;
        set_data();
        bus.in_data[(N_CH-1)*WIDTH +: WIDTH] = WIDTH'('hA5);
        tick();
        check("sel_data", bus.out_data, 'hA5);
        check("sel_ch", bus.out_ch, N_CH - 1);
        check("sel_valid", bus.out_valid, 1);

        // All-ones select: illegal unless N_CH is a power of two.
        bus.sel = '1;
        set_data();
        tick();
        check("illegal_err", bus.sel_err, SEL_MAX_ILLEGAL);
        check("illegal_out_valid", bus.out_valid, !SEL_MAX_ILLEGAL);
        bus.sel      = '0;
        bus.in_valid = '0;
        tick();
        check("illegal_err_clear", bus.sel_err, 0);

        // Round-robin fairness with every channel valid.
        bus.mode     = MODE_RR;
        bus.in_valid = '1;
        for (int i = 0; i < 2 * N_CH; i++) begin
            set_data();
            tick();
            check("rr_fair_ch", bus.out_ch, i % N_CH);
            check("rr_fair_valid", bus.out_valid, 1);
        end

        // Round-robin skip over idle channels: only first and last valid.
        bus.in_valid = N_CH'(1) | (N_CH'(1) << (N_CH - 1));
        for (int i = 0; i < 4; i++) begin
            set_data();
            tick();
            check("rr_skip_ch", bus.out_ch, (i % 2 == 0) ? 0 : N_CH - 1);
        end

        // Backpressure: hold 3C for five cycles, then consume and refill together.
        bus.mode     = MODE_SEL;
        bus.sel      = '0;
        bus.in_valid = N_CH'(1);
        set_data();
        bus.in_data[0 +: WIDTH] = WIDTH'('h3C);
        tick();
        check("bp_load", bus.out_data, 'h3C);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_data();
            bus.in_data[0 +: WIDTH] = WIDTH'('h77);
            tick();
            check("bp_hold_data", bus.out_data, 'h3C);
            check("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        bus.in_data[0 +: WIDTH] = WIDTH'('h5A);
        tick();
        check("bp_next_data", bus.out_data, 'h5A);
        check("bp_next_valid", bus.out_valid, 1);

        // Reset while a word is held.
        bus.mode      = MODE_RR;
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        set_data();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        set_data();
        tick();
        check("rst_first_rr_ch", bus.out_ch, 0);

        // Randomised traffic against the model and scoreboard.
        for (int i = 0; i < 400; i++) begin
            bus.mode      = ($urandom_range(0, 3) == 0) ? MODE_SEL : MODE_RR;
            bus.sel       = CH_W'($urandom);
            bus.in_valid  = N_CH'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_data();
            tick();
        end

        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
